// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 8-word line refill.
// Ports: cpu_* fetch side, mem_* bridge side, flush/flush_busy invalidate-all.
module icache_dm #(
  parameter int INDEX_W = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        flush_busy,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_burst_ok
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, REFILL, RESP, FLUSH
  } state_t;

  state_t state, state_nx;

  logic [31:2]        addr_q;
  logic [3:0]         beat;
  logic [31:0]        resp_q;
  logic               flush_pend;
  logic [INDEX_W-1:0] fidx;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [31:0]        data [LINES*8];

  logic [2:0]         offs;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               beat_take;
  logic [3:0]         beat_sum;
  logic               accept;
  logic               addr_ok_c;
  logic               data_ok_c;
  logic [31:0]        rdata_c;
  logic               mem_en_c;
  logic [31:0]        mem_addr_c;
  logic               blocked;
  logic               unused_bits;

  assign unused_bits = ^cpu_addr[1:0];

  assign offs = addr_q[4:2];
  assign idx  = addr_q[4+INDEX_W:5];
  assign tag  = addr_q[31:5+INDEX_W];
  assign hit  = valid[idx] && (tags[idx] == tag);

  // Beats past the eighth are dropped.
  assign beat_take = mem_data_ok && !beat[3];
  assign beat_sum  = beat + {3'b0, beat_take};

  // A flush in flight or arriving now blocks new requests.
  assign blocked = flush_pend | flush;

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    addr_ok_c  = 1'b0;
    data_ok_c  = 1'b0;
    rdata_c    = 32'h0;
    mem_en_c   = 1'b0;
    mem_addr_c = 32'h0;
    unique case (state)
      IDLE: begin
        addr_ok_c = !blocked;
        if (blocked) begin
          state_nx = FLUSH;
        end else if (cpu_req) begin
          accept   = 1'b1;
          state_nx = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_ok_c = 1'b1;
          rdata_c   = data[{idx, offs}];
          addr_ok_c = !blocked;
          if (cpu_req && !blocked) begin
            accept   = 1'b1;
            state_nx = LOOKUP;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = MISS;
        end
      end
      MISS: begin
        mem_en_c   = 1'b1;
        mem_addr_c = {tag, idx, 5'b0};
        if (mem_addr_ok) state_nx = REFILL;
      end
      REFILL: begin
        if (mem_burst_ok) state_nx = RESP;
      end
      RESP: begin
        data_ok_c = 1'b1;
        rdata_c   = resp_q;
        state_nx  = IDLE;
      end
      FLUSH: begin
        if (&fidx) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cpu_addr_ok = rstn & addr_ok_c;
  assign cpu_data_ok = data_ok_c;
  assign cpu_rdata   = rdata_c;
  assign mem_en      = mem_en_c;
  assign mem_addr    = mem_addr_c;
  assign flush_busy  = flush_pend | (state == FLUSH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      beat       <= '0;
      resp_q     <= '0;
      flush_pend <= 1'b0;
      fidx       <= '0;
      valid      <= '0;
    end else begin
      if (accept) addr_q <= cpu_addr[31:2];
      if (state == MISS && mem_addr_ok) begin
        beat   <= '0;
        resp_q <= '0;
      end
      if (state == REFILL) begin
        if (beat_take) begin
          beat <= beat_sum;
          if (beat[2:0] == offs) resp_q <= mem_rdata;
        end
        if (mem_burst_ok && beat_sum == 4'd8) valid[idx] <= 1'b1;
      end
      if (flush)                      flush_pend <= 1'b1;
      else if (state == FLUSH && &fidx) flush_pend <= 1'b0;
      if (state == FLUSH) begin
        valid[fidx] <= 1'b0;
        fidx        <= fidx + 1'b1;
      end else begin
        fidx <= '0;
      end
    end
  end

  // Line store carries no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (state == REFILL && beat_take) data[{idx, beat[2:0]}] <= mem_rdata;
    if (state == REFILL && mem_burst_ok && beat_sum == 4'd8) tags[idx] <= tag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm with a behavioural refill bridge.
// Stimulus pushes expected responses; a monitor pops and compares them.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        flush_busy;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        mem_burst_ok;

  icache_dm #(.INDEX_W(7)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .cpu_rdata(cpu_rdata),
    .flush(flush), .flush_busy(flush_busy),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .mem_burst_ok(mem_burst_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          refills = 0;
  int          beats  = 0;
  int          burst_len = 8;
  int          hang_after = 99;
  bit          hung = 0;
  logic [31:0] last_maddr = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + ((a - 32'hBFC00000) >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: every response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn === 1'b1 && cpu_data_ok) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp actual=%h required=none", cpu_rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_data", cpu_rdata, e.data);
        if (e.lat >= 0) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Zero-wait bridge; burst_len and hang_after shape the burst.
  initial begin
    mem_addr_ok  = 0;
    mem_data_ok  = 0;
    mem_rdata    = 0;
    mem_burst_ok = 0;
    forever begin
      @(negedge clk);
      if (rstn && mem_en) begin
        refills++;
        beats      = 0;
        last_maddr = mem_addr;
        mem_addr_ok = 1;
        @(negedge clk);
        mem_addr_ok = 0;
        for (int i = 0; i < burst_len; i++) begin
          if (i == hang_after) begin
            mem_data_ok = 0;
            hung = 1;
            while (rstn) @(negedge clk);
            break;
          end
          mem_data_ok  = 1;
          mem_rdata    = mem_word(last_maddr + 32'(i * 4));
          mem_burst_ok = (i == burst_len - 1);
          beats        = i + 1;
          @(negedge clk);
        end
        mem_data_ok  = 0;
        mem_burst_ok = 0;
        mem_rdata    = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input int lat, input bit push);
    int n = 0;
    cpu_req  = 1;
    cpu_addr = a;
    #1;
    while (!cpu_addr_ok && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cpu_addr_ok) begin
      total++;
      $display("FAIL accept_timeout actual=0 required=1 addr=%h", a);
    end else if (push) begin
      sbq.push_back('{d, cyc, lat});
    end
    @(negedge clk);
    cpu_req = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic miss_chk(input string name, input int r0,
                          input logic [31:0] a);
    check(name, 32'(refills - r0), 32'd1);
    check({name, "_maddr"}, last_maddr, a & 32'hFFFFFFE0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;
    int bc;
    int bad;
    rstn     = 0;
    cpu_req  = 0;
    cpu_addr = 0;
    flush    = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_addr_ok", {31'b0, cpu_addr_ok}, 32'd0);
    check("rst_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_flush_busy", {31'b0, flush_busy}, 32'd0);
    @(negedge clk);
    rstn = 1;
    #1;
    check("post_rst_addr_ok", {31'b0, cpu_addr_ok}, 32'd1);
    @(negedge clk);

    r0 = refills;
    issue(32'hBFC00004, 32'h1001, 11, 1);
    drain("cold_drain");
    miss_chk("cold_refill", r0, 32'hBFC00004);

    r0 = refills;
    for (int i = 0; i < 8; i++)
      issue(32'hBFC00000 + 32'(i * 4), 32'h1000 + 32'(i), 1, 1);
    drain("hit_drain");
    check("hit_no_refill", 32'(refills - r0), 32'd0);

    r0 = refills;
    issue(32'hBFC01004, 32'h1401, 11, 1);
    drain("conflict_drain");
    miss_chk("conflict_refill", r0, 32'hBFC01004);
    r0 = refills;
    issue(32'hBFC00004, 32'h1001, 11, 1);
    drain("evict_drain");
    miss_chk("evict_refill", r0, 32'hBFC00004);

    r0 = refills;
    issue(32'hBFC02010, 32'h1804, -1, 1);
    n = 0;
    while (beats < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    bc  = 0;
    bad = 0;
    while (flush_busy && bc < 2000) begin
      if (cpu_addr_ok) bad++;
      @(negedge clk);
      bc++;
    end
    check("flush_busy_ge128", {31'b0, bc >= 128}, 32'd1);
    check("flush_addr_ok_low", 32'(bad), 32'd0);
    drain("flush_drain");
    miss_chk("flush_inflight_refill", r0, 32'hBFC02010);
    r0 = refills;
    issue(32'hBFC00004, 32'h1001, 11, 1);
    drain("post_flush_drain");
    miss_chk("post_flush_refill", r0, 32'hBFC00004);

    burst_len = 4;
    r0 = refills;
    issue(32'hBFC03018, 32'h0, -1, 1);
    drain("short_drain");
    burst_len = 8;
    r0 = refills;
    issue(32'hBFC03018, 32'h1C06, 11, 1);
    drain("short_reaccess_drain");
    miss_chk("short_reaccess_refill", r0, 32'hBFC03018);

    hang_after = 3;
    hung = 0;
    issue(32'hBFC04000, 32'h0, -1, 0);
    n = 0;
    while (!hung && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hang_beats", 32'(beats), 32'd3);
    rstn = 0;
    #1;
    check("mid_rst_addr_ok", {31'b0, cpu_addr_ok}, 32'd0);
    check("mid_rst_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    check("mid_rst_rdata", cpu_rdata, 32'd0);
    check("mid_rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_flush_busy", {31'b0, flush_busy}, 32'd0);
    repeat (2) @(negedge clk);
    hang_after = 99;
    rstn = 1;
    @(negedge clk);
    r0 = refills;
    issue(32'hBFC04000, 32'h2000, 11, 1);
    drain("rst_same_drain");
    miss_chk("rst_same_refill", r0, 32'hBFC04000);
    r0 = refills;
    issue(32'hBFC00004, 32'h1001, 11, 1);
    drain("rst_old_drain");
    miss_chk("rst_old_refill", r0, 32'hBFC00004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
